// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Mode constants (1440x900@60), FSM state type and default widths
//           shared by the VGA raster timing generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_h_active = 1440;
    localparam int c_h_fp     = 80;
    localparam int c_h_sync   = 152;
    localparam int c_h_bp     = 232;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    localparam int c_v_active = 900;
    localparam int c_v_fp     = 3;
    localparam int c_v_sync   = 6;
    localparam int c_v_bp     = 25;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    localparam bit c_h_pol = 1'b0;
    localparam bit c_v_pol = 1'b1;

    localparam int c_cw = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_if.sv
// ============================================================================
// Module  : vga_timing_if
// Brief   : Raster output bundle (syncs, data enable, coordinates, markers).
//           Prefetch request signals exist only with VGA_TIMING_PREFETCH_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_timing_if #(
    parameter int CW = 11
) ();

    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          running;
`ifdef VGA_TIMING_PREFETCH_EN
    logic          pix_req;
    logic [CW-1:0] req_x;
    logic [CW-1:0] req_y;
`endif

`ifdef VGA_TIMING_PREFETCH_EN
    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start, running,
        output pix_req, req_x, req_y
    );
    modport slave (
        input  hsync, vsync, de, x, y, line_start, frame_start, running,
        input  pix_req, req_x, req_y
    );
`else
    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start, running
    );
    modport slave (
        input  hsync, vsync, de, x, y, line_start, frame_start, running
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer for slow level signals entering clk domain.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output      logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Lock-gated raster timing generator with registered syncs, DE and
//           coordinates. Define VGA_TIMING_PREFETCH_EN for pix_req/req_x/req_y.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit H_POL    = c_h_pol,
    parameter bit V_POL    = c_v_pol,
    parameter int CW       = c_cw
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      pll_locked,
    vga_timing_if.master   vif
);

    localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_h_last     = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] c_v_last     = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic          w_lk_s;
    state_t        r_state;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lk_s)
    );

    // Losing lock drops straight back to the origin; no partial line is finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                    if (w_lk_s) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_lk_s) begin
                        r_state <= IDLE;
                        r_h_cnt <= '0;
                        r_v_cnt <= '0;
                    end else if (r_h_cnt == c_h_last) begin
                        r_h_cnt <= '0;
                        r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + CW'(1);
                    end else begin
                        r_h_cnt <= r_h_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                end
            endcase
        end
    end

    logic w_run;
    logic w_vis;
    logic w_hs_act;
    logic w_vs_act;

    assign w_run    = (r_state == RUN);
    assign w_vis    = w_run && (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_act = w_run && (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_act = w_run && (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? H_POL : ~H_POL;
            r_vsync       <= w_vs_act ? V_POL : ~V_POL;
            r_de          <= w_vis;
            r_x           <= w_vis ? r_h_cnt : '0;
            r_y           <= w_vis ? r_v_cnt : '0;
            r_line_start  <= w_run && (r_h_cnt == '0);
            r_frame_start <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.de          = r_de;
    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
    assign vif.running     = w_run;

`ifdef VGA_TIMING_PREFETCH_EN
    // Live-counter decode: a one-cycle pixel source answering this lands on de.
    assign vif.pix_req = w_vis;
    assign vif.req_x   = w_vis ? r_h_cnt : '0;
    assign vif.req_y   = w_vis ? r_v_cnt : '0;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 1440x900@60 display mode.
- Runs on the 106.5 MHz PLL output clock and consumes the PLL lock indicator.
- Produces registered hsync/vsync/data-enable and pixel coordinates for the pinpong video path.
- Holds the raster idle until lock is stable; restarts cleanly whenever lock is lost.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (clocks)
- H_SYNC, 152, hsync width (clocks)
- H_BP, 232, horizontal back porch (clocks)
- V_ACTIVE, 900, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 25, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 1, vsync active level (1 = active-high)
- CW, 11, width of the counter and coordinate fields

Ports:
- clk  in  1  pixel clock, 106.5 MHz from the PLL
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock; asynchronous to clk, synchronized internally
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- de  out  1  data enable, high during the visible region
- x  out  CW  pixel column; valid when de=1
- y  out  CW  pixel row; valid when de=1
- line_start  out  1  one-clock pulse at h=0 of every line
- frame_start  out  1  one-clock pulse at h=0, v=0
- running  out  1  high while the FSM is in RUN

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - hsync=~H_POL, vsync=~V_POL (inactive levels)
  - de=0, x=0, y=0, line_start=0, frame_start=0, running=0
  - h_cnt=0, v_cnt=0, state=IDLE, lock synchronizer flops=0
- Lock synchronizer: 2-flop, giving lk_s.
- FSM:
  - IDLE: counters held at 0, all outputs at inactive levels. Go to RUN when lk_s=1.
  - RUN: counters advance. Go to IDLE on the next edge when lk_s=0.
- Counters, in RUN only:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL=1904), then wraps to 0.
  - v_cnt increments on the h_cnt wrap and wraps to 0 after V_TOTAL-1 (V_TOTAL=934).
- Output decode, registered with 1 clk latency from the counters; outputs are gated by state==RUN:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 1520..1671
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 903..908
  - x = h_cnt and y = v_cnt when de, else 0
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0)
- Lock loss mid-frame:
  - Next edge: state=IDLE and counters=0.
  - The edge after that: all outputs inactive.
  - No partial-line completion.
- Lock regain: raster restarts at h=0, v=0, so frame_start is the first pulse after re-entry.
- Async reset mid-frame: all flops clear immediately. Restart requires lk_s to re-propagate (2 clks).
- Width rule: CW must satisfy 2^CW > max(H_TOTAL, V_TOTAL). Counter compares are unsigned.

Optional Feature:
- Macro: VGA_TIMING_PREFETCH_EN
- Defined:
  - Adds outputs pix_req (1), req_x (CW), req_y (CW).
  - These are combinational decodes of the live counters, gated by RUN, so they lead de/x/y by exactly 1 clk.
  - Purpose: a 1-cycle-latency pixel source lines up with de.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constants: default H/V porch/sync/active values, H_TOTAL, V_TOTAL, polarities
  - FSM state enum {IDLE, RUN}
  - CW default
- Sub-module sync_2ff (parameterised width, async active-low reset) for the pll_locked synchronizer. It is reused by other cross-domain inputs.

Test Plan:
- Lock-up timing: rst_n deasserted, then pll_locked rises -> running=1 after 3 edges; de and frame_start first high at the 4th edge; x=0, y=0.
- Line structure: over one line -> de high 1440 clks; hsync goes low 1520 clks after the de rise, stays low 152 clks; line period is 1904 clks.
- Frame structure: frame_start period = 1,778,336 clks; vsync high for 6 lines beginning at line 903; de low for lines 900..933.
- Wrap: at x=1439, y=899 -> next de rise shows x=0, y=0 with frame_start=1 after 464 blank clks plus 34 blank lines.
- Lock loss: pll_locked falls at line 500 -> de/hsync/vsync go inactive within 4 clks. On relock the first active pixel is x=0, y=0 with frame_start.
- Async reset mid-line: rst_n pulsed low for 1 ns -> outputs go to reset values without waiting for a clock edge. With VGA_TIMING_PREFETCH_EN defined, pix_req leads de by 1 clk on every line.
